quad_step_decoder: RTL and testbench

- Quadrature front-end that drives the up/down counter's control interface (count_en, count_dir, count_clr) from external encoder signals A, B and index I.
- Synchronises and glitch-filters the raw inputs, then decodes Gray-code transitions into single-cycle step pulses with a direction.
- Flags illegal double-bit transitions.
- Sits between the encoder pins and an N-bit position counter.

---
 rtl/quad_step_decoder.sv | 213 +++++++++++++++++++++
 tb/tb_quad_step_decoder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_step_decoder.sv
// ============================================================================
//  Module   : quad_step_decoder
//  Purpose  : Quadrature encoder front-end. Synchronises and glitch-filters
//             the raw A/B/I encoder pins, decodes Gray-code transitions into
//             single-cycle step pulses with a direction, generates a counter
//             clear from the index rising edge, and counts illegal
//             double-bit transitions.
//  Ports    : clk, rst_n (async, active-low)
//             enable      - gates step_en / step_clr
//             qa, qb, qi  - raw asynchronous encoder inputs
//             idx_clr_en  - allow index rise to produce step_clr
//             err_clr     - clears err_flag / err_cnt
//             step_en     - one-cycle pulse per valid quadrature edge
//             step_dir    - 1 = forward, 0 = reverse (holds last value)
//             step_clr    - one-cycle pulse on filtered index rise
//             err_flag    - sticky illegal-transition flag
//             err_cnt     - saturating illegal-transition count
//             stalled     - no step for STALL_CYC cycles (QDEC_STALL_EN only)
//  Options  : define QDEC_STALL_EN to add the idle counter, the STALL_CYC
//             parameter and the stalled output.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module quad_step_decoder #(
    parameter int FILT_LEN  = 3,
    parameter int ERR_W     = 8
`ifdef QDEC_STALL_EN
    ,
    parameter int STALL_CYC = 1000
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             qa,
    input  logic             qb,
    input  logic             qi,
    input  logic             idx_clr_en,
    input  logic             err_clr,
    output logic             step_en,
    output logic             step_dir,
    output logic             step_clr,
    output logic             err_flag,
    output logic [ERR_W-1:0] err_cnt
`ifdef QDEC_STALL_EN
    ,
    output logic             stalled
`endif
);

    // Filter counter terminal value: the FILT_LEN-th differing sample.
    localparam logic [3:0] c_FCNT_LAST = 4'(FILT_LEN - 1);
    // SEED covers the synchroniser plus filter latency so the first
    // captured AB reflects the real encoder position.
    localparam logic [4:0] c_SEED_LAST = 5'(FILT_LEN + 2);

    localparam logic [0:0] c_SEED = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;

    // Channel index: 0 = A, 1 = B, 2 = I
    logic [2:0] w_raw;
    logic [2:0] r_sync1;
    logic [2:0] r_sync2;
    logic [2:0] r_filt;
    logic [3:0] r_fcnt [3];

    logic [0:0] r_state;
    logic [4:0] r_seed_cnt;
    logic [1:0] r_ab_prev;
    logic       r_i_prev;

    logic [1:0] w_ab;
    logic [1:0] w_fwd_next;
    logic       w_run;
    logic       w_fwd;
    logic       w_rev;
    logic       w_illegal;
    logic       w_i_rise;

    assign w_raw = {qi, qb, qa};

    // ------------------------------------------------------------------
    // Synchronisers and per-channel persistence filters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_filt  <= '0;
            for (int ch = 0; ch < 3; ch++) begin
                r_fcnt[ch] <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int ch = 0; ch < 3; ch++) begin
                if (r_sync2[ch] == r_filt[ch]) begin
                    r_fcnt[ch] <= '0;
                end else if (r_fcnt[ch] == c_FCNT_LAST) begin
                    r_filt[ch] <= r_sync2[ch];
                    r_fcnt[ch] <= '0;
                end else begin
                    r_fcnt[ch] <= r_fcnt[ch] + 4'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Gray-code decode. Forward order of {A,B}: 00 -> 10 -> 11 -> 01 -> 00
    // ------------------------------------------------------------------
    assign w_ab  = {r_filt[0], r_filt[1]};
    assign w_run = (r_state == c_RUN);

    always_comb begin
        w_fwd_next = 2'b00;
        case (r_ab_prev)
            2'b00:   w_fwd_next = 2'b10;
            2'b10:   w_fwd_next = 2'b11;
            2'b11:   w_fwd_next = 2'b01;
            default: w_fwd_next = 2'b00;
        endcase
    end

    assign w_illegal = (w_ab == ~r_ab_prev);
    assign w_fwd     = (w_ab == w_fwd_next);
    assign w_rev     = (w_ab != r_ab_prev) && !w_fwd && !w_illegal;
    assign w_i_rise  = r_filt[2] & ~r_i_prev;

    // ------------------------------------------------------------------
    // Control FSM, step/clear outputs and error tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_SEED;
            r_seed_cnt <= '0;
            r_ab_prev  <= '0;
            r_i_prev   <= 1'b0;
            step_en    <= 1'b0;
            step_dir   <= 1'b0;
            step_clr   <= 1'b0;
            err_flag   <= 1'b0;
            err_cnt    <= '0;
        end else begin
            r_i_prev <= r_filt[2];
            step_en  <= 1'b0;
            step_clr <= 1'b0;

            case (r_state)
                c_SEED: begin
                    r_seed_cnt <= r_seed_cnt + 5'd1;
                    if (r_seed_cnt == c_SEED_LAST) begin
                        r_ab_prev <= w_ab;
                        r_state   <= c_RUN;
                    end
                end
                default: begin
                    // previous-AB tracks even when disabled so re-enable
                    // never sees a stale position
                    r_ab_prev <= w_ab;
                    if (enable && (w_fwd || w_rev)) begin
                        step_en  <= 1'b1;
                        step_dir <= w_fwd;
                    end
                    if (enable && idx_clr_en && w_i_rise) begin
                        step_clr <= 1'b1;
                    end
                end
            endcase

            // A new illegal transition wins over a simultaneous clear and
            // counts as the first error after it.
            if (w_run && w_illegal) begin
                err_flag <= 1'b1;
                if (err_clr) begin
                    err_cnt <= ERR_W'(1);
                end else if (!(&err_cnt)) begin
                    err_cnt <= err_cnt + ERR_W'(1);
                end
            end else if (err_clr) begin
                err_flag <= 1'b0;
                err_cnt  <= '0;
            end
        end
    end

`ifdef QDEC_STALL_EN
    // ------------------------------------------------------------------
    // Idle counter: cleared by a registered step so stalled falls the
    // cycle after the step pulse.
    // ------------------------------------------------------------------
    localparam int c_IDLE_W = $clog2(STALL_CYC + 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_MAX = c_IDLE_W'(STALL_CYC);

    logic [c_IDLE_W-1:0] r_idle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle <= '0;
        end else if (!w_run || step_en) begin
            r_idle <= '0;
        end else if (r_idle != c_IDLE_MAX) begin
            r_idle <= r_idle + c_IDLE_W'(1);
        end
    end

    assign stalled = (r_idle >= c_IDLE_MAX);
`endif

endmodule

`default_nettype wire

// File: tb/tb_quad_step_decoder.sv
// ============================================================================
//  Module   : tb_quad_step_decoder
//  Purpose  : Directed self-checking bench for quad_step_decoder
//             (FILT_LEN=3, ERR_W=8, STALL_CYC=20 when QDEC_STALL_EN).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_quad_step_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       qa;
    logic       qb;
    logic       qi;
    logic       idx_clr_en;
    logic       err_clr;
    logic       step_en;
    logic       step_dir;
    logic       step_clr;
    logic       err_flag;
    logic [7:0] err_cnt;
`ifdef QDEC_STALL_EN
    logic       stalled;
`endif

    int n_total = 0;
    int n_bad   = 0;

    int acc_pulse;
    int acc_clr;
    int acc_both;
    int acc_first;
    int acc_dir;
    int tick_no;
    logic [1:0] cur_ab;

    always #5 clk = ~clk;

    quad_step_decoder #(
        .FILT_LEN  (3),
        .ERR_W     (8)
`ifdef QDEC_STALL_EN
        ,
        .STALL_CYC (20)
`endif
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .qa         (qa),
        .qb         (qb),
        .qi         (qi),
        .idx_clr_en (idx_clr_en),
        .err_clr    (err_clr),
        .step_en    (step_en),
        .step_dir   (step_dir),
        .step_clr   (step_clr),
        .err_flag   (err_flag),
        .err_cnt    (err_cnt)
`ifdef QDEC_STALL_EN
        ,
        .stalled    (stalled)
`endif
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_acc;
        acc_pulse = 0;
        acc_clr   = 0;
        acc_both  = 0;
        acc_first = 0;
        acc_dir   = -1;
        tick_no   = 0;
    endtask

    // Advance n cycles, tallying output pulses.
    task automatic hold(input int n);
        for (int i = 0; i < n; i++) begin
            tick;
            tick_no++;
            if (step_en) begin
                acc_pulse++;
                if (acc_first == 0) acc_first = tick_no;
                acc_dir = int'(step_dir);
            end
            if (step_clr) acc_clr++;
            if (step_en && step_clr) acc_both++;
        end
    endtask

    task automatic drive_ab(input logic [1:0] ab);
        cur_ab = ab;
        qa     = ab[1];
        qb     = ab[0];
    endtask

    // Four AB values, most significant pair first, each held 10 cycles.
    task automatic seq4(input logic [7:0] v);
        for (int k = 3; k >= 0; k--) begin
            drive_ab(v[2*k+1 -: 2]);
            hold(10);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b1;
        qi         = 1'b0;
        idx_clr_en = 1'b0;
        err_clr    = 1'b0;
        drive_ab(2'b11);
        repeat (3) tick;

        chk("rst_step_en",  step_en,  0);
        chk("rst_step_dir", step_dir, 0);
        chk("rst_step_clr", step_clr, 0);
        chk("rst_err_flag", err_flag, 0);
        chk("rst_err_cnt",  err_cnt,  0);
`ifdef QDEC_STALL_EN
        chk("rst_stalled",  stalled,  0);
`endif

        // SEED: six quiet cycles, previous-AB ends at 11
        rst_n = 1'b1;
        clr_acc;
        hold(6);
        chk("seed_steps", acc_pulse, 0);
        chk("seed_err",   err_flag,  0);

        // 11 -> 01 is forward only if SEED captured 11
        clr_acc;
        drive_ab(2'b01);
        hold(10);
        chk("seed_ab_fwd_cnt", acc_pulse, 1);
        chk("seed_ab_fwd_dir", acc_dir,   1);
        chk("seed_ab_latency", acc_first, 6);
        drive_ab(2'b00);
        hold(10);

        // Forward cycle
        clr_acc;
        seq4(8'b10_11_01_00);
        chk("fwd_pulses",  acc_pulse, 4);
        chk("fwd_dir",     acc_dir,   1);
        chk("fwd_latency", acc_first, 6);
        chk("fwd_err",     err_flag,  0);

        // Reverse cycle
        clr_acc;
        seq4(8'b01_11_10_00);
        chk("rev_pulses", acc_pulse, 4);
        chk("rev_dir",    acc_dir,   0);

        // Two short glitches separated by one clean sample
        clr_acc;
        qa = 1'b1; hold(2);
        qa = 1'b0; hold(1);
        qa = 1'b1; hold(2);
        qa = 1'b0; hold(12);
        chk("glitch_pulses",   acc_pulse, 0);
        chk("glitch_dir_hold", step_dir,  0);
        chk("glitch_err",      err_flag,  0);

        // Illegal double-bit jump
        clr_acc;
        drive_ab(2'b11);
        hold(10);
        chk("illegal_pulses", acc_pulse, 0);
        chk("illegal_flag",   err_flag,  1);
        chk("illegal_cnt",    err_cnt,   1);

        for (int i = 1; i < 300; i++) begin
            drive_ab(~cur_ab);
            hold(6);
            if (i == 199) chk("err_cnt_200", err_cnt, 200);
        end
        chk("err_cnt_sat",     err_cnt,   255);
        chk("err_flag_sat",    err_flag,  1);
        chk("err_loop_pulses", acc_pulse, 0);

        // Clear coincident with a new illegal transition
        drive_ab(2'b11);
        hold(5);
        chk("err_pre_clr", err_cnt, 255);
        err_clr = 1'b1;
        hold(1);
        err_clr = 1'b0;
        chk("err_clr_coinc_flag", err_flag, 1);
        chk("err_clr_coinc_cnt",  err_cnt,  1);

        err_clr = 1'b1;
        hold(1);
        err_clr = 1'b0;
        chk("err_clr_flag", err_flag, 0);
        chk("err_clr_cnt",  err_cnt,  0);

        drive_ab(2'b01); hold(10);
        drive_ab(2'b00); hold(10);

        // Index rise coincident with a forward step
        idx_clr_en = 1'b1;
        clr_acc;
        drive_ab(2'b10);
        qi = 1'b1;
        hold(10);
        qi = 1'b0;
        hold(10);
        chk("idx_pulses", acc_pulse, 1);
        chk("idx_clr",    acc_clr,   1);
        chk("idx_both",   acc_both,  1);
        chk("idx_dir",    acc_dir,   1);

        // Disabled: motion and index ignored, no step on re-enable
        enable = 1'b0;
        clr_acc;
        drive_ab(2'b11);
        qi = 1'b1;
        hold(10);
        qi = 1'b0;
        hold(10);
        enable = 1'b1;
        hold(10);
        chk("dis_pulses", acc_pulse, 0);
        chk("dis_clr",    acc_clr,   0);
        chk("dis_err",    err_flag,  0);

`ifdef QDEC_STALL_EN
        chk("stall_idle", stalled, 1);
        drive_ab(2'b01);
        for (int i = 0; i < 10; i++) begin
            tick;
            if (step_en) break;
        end
        chk("stall_step_seen", step_en, 1);
        chk("stall_in_step",   stalled, 1);
        tick;
        chk("stall_drop", stalled, 0);
        repeat (19) tick;
        chk("stall_19", stalled, 0);
        tick;
        chk("stall_20", stalled, 1);
`endif

        // Asynchronous reset mid-operation
        drive_ab(~cur_ab);
        hold(10);
        chk("pre_rst_err", err_flag, 1);
        chk("pre_rst_dir", step_dir, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_err_flag", err_flag, 0);
        chk("mid_rst_err_cnt",  err_cnt,  0);
        chk("mid_rst_dir",      step_dir, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
